// File: rtl/decoder_pkg.sv
// Shared widths and helper functions for the 3-to-8 one-hot decoder.
package decoder_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 1 << SEL_W;

    // Active-high one-hot decode: bit 'sel' set when enabled, all zero otherwise.
    function automatic logic [OUT_W-1:0] onehot_decode(input logic [SEL_W-1:0] sel,
                                                        input logic             en);
        logic [OUT_W-1:0] d;
        d = '0;
        if (en) begin
            d[sel] = 1'b1;
        end
        return d;
    endfunction

    // Level an output line rests at when it is not selected.
    function automatic logic [OUT_W-1:0] idle_level(input bit active_low);
        return active_low ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    endfunction

endpackage

// File: rtl/decoder_3to8_core.sv
// Pure combinational decode with output polarity applied; no state.
module decoder_3to8_core
    import decoder_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [OUT_W-1:0] y_d,
    output logic             valid_d
);

    logic [OUT_W-1:0] d_high;

    // Decode in the active-high view, then invert for active-low builds.
    always_comb begin
        d_high  = onehot_decode(sel, en);
        y_d     = OUT_ACTIVE_LOW ? ~d_high : d_high;
        valid_d = en;
    end

endmodule

// File: rtl/decoder_3to8.sv
// Registered (or optionally combinational) 3-to-8 one-hot decoder.
// Output qualifier: 'valid' has no ready; when valid=1, Y carries exactly one
// asserted line for the enabled S; when valid=0, every Y line sits at idle.
module decoder_3to8
    import decoder_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW  = 1'b0,
    parameter bit REGISTER_OUTPUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] S,
    output logic [OUT_W-1:0] Y,
    output logic             valid
);

    localparam logic [OUT_W-1:0] IDLE = idle_level(OUT_ACTIVE_LOW);

    logic [OUT_W-1:0] y_d;
    logic             valid_d;

    decoder_3to8_core #(
        .OUT_ACTIVE_LOW(OUT_ACTIVE_LOW)
    ) u_core (
        .sel    (S),
        .en     (en),
        .y_d    (y_d),
        .valid_d(valid_d)
    );

    generate
        if (REGISTER_OUTPUT) begin : g_reg
            // One-cycle pipeline stage; reset drops straight to idle without a clock.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    Y     <= IDLE;
                    valid <= 1'b0;
                end else begin
                    Y     <= y_d;
                    valid <= valid_d;
                end
            end
        end else begin : g_comb
            // Zero-latency path; reset still overrides to idle.
            always_comb begin
                Y     = IDLE;
                valid = 1'b0;
                if (!rst) begin
                    Y     = y_d;
                    valid = valid_d;
                end
            end
        end
    endgenerate

    // Check the one-hot invariant and flag unknown selects at each clock edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (en) begin
                assert (!$isunknown(S));
            end
            if (valid) begin
                assert ($onehot(Y ^ IDLE));
            end else begin
                assert (Y == IDLE);
            end
        end
    end

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed bench for decoder_3to8: registered, active-low and combinational builds.
module tb_decoder_3to8;
    import decoder_pkg::*;

    logic             clk;
    logic             rst;
    logic             en;
    logic [SEL_W-1:0] S;

    logic [OUT_W-1:0] y_reg, y_al, y_comb;
    logic             valid_reg, valid_al, valid_comb;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [7:0] SWEEP_EXP [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                             8'h10, 8'h20, 8'h40, 8'h80};

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0), .REGISTER_OUTPUT(1'b1)) u_dut_reg (
        .clk(clk), .rst(rst), .en(en), .S(S), .Y(y_reg), .valid(valid_reg)
    );

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1), .REGISTER_OUTPUT(1'b1)) u_dut_al (
        .clk(clk), .rst(rst), .en(en), .S(S), .Y(y_al), .valid(valid_al)
    );

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0), .REGISTER_OUTPUT(1'b0)) u_dut_comb (
        .clk(clk), .rst(rst), .en(en), .S(S), .Y(y_comb), .valid(valid_comb)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with an enabled select present.
        rst = 1'b1;
        en  = 1'b1;
        S   = 3'b101;
        #1;
        check("rst_imm_y", y_reg, 8'h00);
        check_bit("rst_imm_valid", valid_reg, 1'b0);
        check("rst_imm_y_al", y_al, 8'hFF);
        check("rst_imm_y_comb", y_comb, 8'h00);
        check_bit("rst_imm_valid_comb", valid_comb, 1'b0);

        @(posedge clk); #1;
        check("rst_edge_y", y_reg, 8'h00);
        check_bit("rst_edge_valid", valid_reg, 1'b0);
        check("rst_edge_y_al", y_al, 8'hFF);

        // Release: combinational build decodes at once, registered waits an edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_comb_y", y_comb, 8'h20);
        check_bit("rel_comb_valid", valid_comb, 1'b1);
        check("rel_pre_edge_y", y_reg, 8'h00);
        @(posedge clk); #1;
        check("rel_first_y", y_reg, 8'h20);
        check_bit("rel_first_valid", valid_reg, 1'b1);
        check("rel_first_y_al", y_al, 8'hDF);

        // Full sweep, one select per cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            S = 3'(i);
            #1;
            check($sformatf("sweep_comb_y_%0d", i), y_comb, SWEEP_EXP[i]);
            @(posedge clk); #1;
            check($sformatf("sweep_y_%0d", i), y_reg, SWEEP_EXP[i]);
            check_bit($sformatf("sweep_valid_%0d", i), valid_reg, 1'b1);
            check($sformatf("sweep_y_al_%0d", i), y_al, ~SWEEP_EXP[i]);
        end

        // Enable gating.
        @(negedge clk);
        en = 1'b0;
        S  = 3'b011;
        #1;
        check("gate_comb_y", y_comb, 8'h00);
        check_bit("gate_comb_valid", valid_comb, 1'b0);
        @(posedge clk); #1;
        check("gate_y", y_reg, 8'h00);
        check_bit("gate_valid", valid_reg, 1'b0);
        check("gate_y_al", y_al, 8'hFF);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        check("ungate_y", y_reg, 8'h08);
        check_bit("ungate_valid", valid_reg, 1'b1);

        // Asynchronous reset between edges while Y shows 8'h10.
        @(negedge clk);
        S = 3'b100;
        @(posedge clk); #1;
        check("mid_pre_y", y_reg, 8'h10);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_y", y_reg, 8'h00);
        check_bit("mid_rst_valid", valid_reg, 1'b0);
        check("mid_rst_y_al", y_al, 8'hFF);
        check("mid_rst_y_comb", y_comb, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Active-low decode of S=6.
        S = 3'b110;
        @(posedge clk); #1;
        check("al_y_6", y_al, 8'hBF);
        check_bit("al_valid_6", valid_al, 1'b1);
        check("al_reg_y_6", y_reg, 8'h40);

        // Combinational build: 0 -> 7 with no clock in between.
        @(negedge clk);
        S = 3'b000;
        #1;
        check("comb_y_0", y_comb, 8'h01);
        S = 3'b111;
        #1;
        check("comb_y_7", y_comb, 8'h80);
        check_bit("comb_valid_7", valid_comb, 1'b1);

        // One-hot invariant on the combinational build for every code.
        for (int i = 0; i < 8; i++) begin
            S = 3'(i);
            #1;
            n_tests++;
            assert ($onehot(y_comb) && valid_comb === 1'b1) else begin
                n_fail++;
                $error("FAIL comb_onehot_%0d observed=%h expected one-hot", i, y_comb);
            end
        end

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
